// File: rtl/fsm_sched_pkg.sv
// fsm_sched_pkg: shared types, widths and helpers for the sequencer scheduler.
// Contents: state_t (scheduler FSM states), GOOD_CNT_W (good-cycle counter width),
//           MAX_REQ/IDX_W (requester limits), onehot_to_idx (one-hot to index).
package fsm_sched_pkg;

    localparam int MAX_REQ    = 8;
    localparam int IDX_W      = 3;
    localparam int GOOD_CNT_W = 3;

    typedef enum logic [2:0] {IDLE, START, RUN, STOP, DONE} state_t;

    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++)
            if (oh[i]) idx = IDX_W'(i);
        return idx;
    endfunction

endpackage

// File: rtl/fsm_sched_if.sv
// fsm_sched_if: client and sequencer signals of the scheduler.
// Signals: req (client requests), grant/done/err (per-requester status),
//          busy, seq_start/seq_stop (to sequencer), seq_good/seq_bad (from sequencer).
// Modports: slave = scheduler side, master = environment (clients + sequencer).
interface fsm_sched_if #(parameter int N_REQ = 4);

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] grant;
    logic [N_REQ-1:0] done;
    logic [N_REQ-1:0] err;
    logic             busy;
    logic             seq_start;
    logic             seq_stop;
    logic             seq_good;
    logic             seq_bad;

    modport slave  (input  req, seq_good, seq_bad,
                    output grant, done, err, busy, seq_start, seq_stop);
    modport master (output req, seq_good, seq_bad,
                    input  grant, done, err, busy, seq_start, seq_stop);

endinterface

// File: rtl/fsm_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick among N_REQ requesters.
// Ports: i_req (request vector), i_ptr (last served index),
//        o_win (one-hot winner), o_valid (some request present).
module rr_arbiter
    import fsm_sched_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_win,
    output logic             o_valid
);

    logic w_found;

    // Offset k = 1..N_REQ walks upward from ptr+1 with wrap; the first hit wins.
    always_comb begin
        o_win   = '0;
        w_found = 1'b0;
        for (int k = 1; k <= N_REQ; k++)
            for (int i = 0; i < N_REQ; i++)
                if (!w_found && i_req[i] && i == (int'(i_ptr) + k) % N_REQ) begin
                    o_win[i] = 1'b1;
                    w_found  = 1'b1;
                end
    end

    assign o_valid = |i_req;

endmodule

// File: rtl/fsm_sched.sv
// fsm_sched: round-robin scheduler sharing one good/bad sequencer among N_REQ clients.
// Ports: clk (rising edge), rst (asynchronous, active-low),
//        bus (fsm_sched_if.slave: req in, grant/done/err/busy/seq_start/seq_stop out,
//        seq_good/seq_bad in). All outputs are registered.
module fsm_sched
    import fsm_sched_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int GOOD_LEN = 3,
    parameter int TIMEOUT  = 8
) (
    input  logic         clk,
    input  logic         rst,
    fsm_sched_if.slave   bus
);

    localparam int TMR_W = $clog2(TIMEOUT);

    state_t                r_state;
    logic [N_REQ-1:0]      r_grant;
    logic [N_REQ-1:0]      r_done;
    logic [N_REQ-1:0]      r_err;
    logic                  r_busy;
    logic                  r_start;
    logic                  r_stop;
    logic                  r_tmo;
    logic [GOOD_CNT_W-1:0] r_good;
    logic [TMR_W-1:0]      r_timer;
    logic [IDX_W-1:0]      r_ptr;
    logic [N_REQ-1:0]      w_win;
    logic                  w_valid;
    logic                  w_ok;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .i_req   (bus.req),
        .i_ptr   (r_ptr),
        .o_win   (w_win),
        .o_valid (w_valid)
    );

    assign w_ok = !r_tmo && r_good == GOOD_CNT_W'(GOOD_LEN);

    // Outputs are set on the transition into the state they belong to, so each
    // pulse lines up with its state while still coming straight from a flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_done  <= '0;
            r_err   <= '0;
            r_busy  <= 1'b0;
            r_start <= 1'b0;
            r_stop  <= 1'b0;
            r_tmo   <= 1'b0;
            r_good  <= '0;
            r_timer <= '0;
            r_ptr   <= IDX_W'(N_REQ - 1);
        end else begin
            case (r_state)
                IDLE: if (w_valid) begin
                    r_grant <= w_win;
                    r_start <= 1'b1;
                    r_busy  <= 1'b1;
                    r_state <= START;
                end
                START: begin
                    r_start <= 1'b0;
                    r_good  <= '0;
                    r_timer <= '0;
                    r_state <= RUN;
                end
                RUN: begin
                    r_timer <= r_timer + 1'b1;
                    if (bus.seq_good && r_good != '1) r_good <= r_good + 1'b1;
                    // seq_bad beats a simultaneous timeout
                    if (bus.seq_bad || r_timer == TMR_W'(TIMEOUT - 1)) begin
                        r_tmo   <= !bus.seq_bad;
                        r_stop  <= 1'b1;
                        r_state <= STOP;
                    end
                end
                STOP: begin
                    r_stop  <= 1'b0;
                    r_done  <= w_ok ? r_grant : '0;
                    r_err   <= w_ok ? '0 : r_grant;
                    r_state <= DONE;
                end
                DONE: begin
                    r_done  <= '0;
                    r_err   <= '0;
                    r_ptr   <= onehot_to_idx(MAX_REQ'(r_grant));
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.grant     = r_grant;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
    assign bus.busy      = r_busy;
    assign bus.seq_start = r_start;
    assign bus.seq_stop  = r_stop;

endmodule

// File: tb/tb_fsm_sched.sv
// tb_fsm_sched: randomized scoreboard bench for fsm_sched with a behavioural sequencer.
// Ports: none (top-level bench).
module tb_fsm_sched;

    localparam int N  = 4;
    localparam int GL = 3;
    localparam int TO = 8;

    typedef struct {
        logic [N-1:0] g;
        bit           ok;
        int           lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    fsm_sched_if #(.N_REQ(N)) bus ();

    fsm_sched #(.N_REQ(N), .GOOD_LEN(GL), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t         sb[$];
    int           checks = 0;
    int           errors = 0;
    int           last   = N - 1;
    int           seq_ng = 0;
    bit           seq_to = 1'b1;
    int           cyc    = 0;
    int           gcyc   = 0;
    logic [N-1:0] prev_g = '0;
    logic         prev_stop = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Round robin from the specification: first set bit above the last owner, wrapping.
    function automatic int pick(input logic [N-1:0] r);
        for (int k = 1; k <= N; k++)
            if (r[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    // Sequencer: after seeing start, ng good cycles then one bad cycle; silent in timeout mode.
    initial begin
        bus.seq_good = 1'b0;
        bus.seq_bad  = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (rst && bus.seq_start && !seq_to) begin
                int n;
                n = seq_ng;
                for (int i = 0; i < n; i++) begin
                    @(posedge clk); #1;
                    bus.seq_good = 1'b1;
                end
                @(posedge clk); #1;
                bus.seq_good = 1'b0;
                bus.seq_bad  = 1'b1;
                @(posedge clk); #1;
                bus.seq_bad  = 1'b0;
            end
        end
    end

    // Monitor: invariants every cycle, grant checked on its rising edge,
    // done/err popped from the scoreboard with the grant-to-result latency.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            prev_g    = '0;
            prev_stop = 1'b0;
        end else begin
            cyc++;
            chk("grant_onehot0", 32'($onehot0(bus.grant)), 1);
            chk("done_err_excl", 32'((|bus.done) && (|bus.err)), 0);
            chk("busy", bus.busy, 32'(|bus.grant));
            if (bus.grant != '0 && prev_g == '0) begin
                gcyc = cyc;
                chk("seq_start_with_grant", bus.seq_start, 1);
                if (sb.size() == 0) chk("unexpected_grant", bus.grant, 0);
                else chk("grant", bus.grant, sb[0].g);
            end
            if (|(bus.done | bus.err)) begin
                if (sb.size() == 0) chk("unexpected_result", bus.done | bus.err, 0);
                else begin
                    e = sb.pop_front();
                    chk("done", bus.done, e.ok ? e.g : '0);
                    chk("err", bus.err, e.ok ? '0 : e.g);
                    chk("latency", cyc - gcyc, e.lat);
                    chk("seq_stop_before_result", prev_stop, 1);
                end
            end
            prev_g    = bus.grant;
            prev_stop = bus.seq_stop;
        end
    end

    task automatic finish_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    // One service: push the expected outcome, present req, apply a mid-service
    // action (1 = withdraw, 2 = random change), wait for the result pulse.
    task automatic serve(input logic [N-1:0] r, input int ng, input bit to, input int act);
        exp_t e;
        int   w;
        bit   seen;
        w     = pick(r);
        e.g   = N'(1) << w;
        e.ok  = !to && ng == GL;
        e.lat = (to ? TO : ng + 1) + 2;
        sb.push_back(e);
        last    = w;
        seq_ng  = ng;
        seq_to  = to;
        bus.req = r;
        seen    = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk); #1;
            if (i == 2 && act == 1) bus.req = '0;
            if (i == 2 && act == 2) bus.req = N'($urandom);
            seen = |(bus.done | bus.err);
        end
        if (!seen) begin
            chk("result_within_bound", 0, 1);
            finish_run();
        end
        @(posedge clk); #1;
    endtask

    initial begin
        logic [N-1:0] r;
        int           m;
        int           w;
        exp_t         e0;
        bus.req = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {bus.grant, bus.done, bus.err, bus.busy, bus.seq_start, bus.seq_stop}, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        serve(4'b0001, GL, 1'b0, 0);
        repeat (5) serve(4'b1111, GL, 1'b0, 0);
        serve(4'b0100, 2, 1'b0, 0);
        serve(4'b0100, 0, 1'b1, 0);
        serve(4'b0100, GL, 1'b0, 0);
        serve(4'b0010, GL, 1'b0, 1);
        bus.req = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_after_withdraw", bus.busy, 0);

        for (int t = 0; t < 40; t++) begin
            do r = N'($urandom); while (r == '0);
            m = $urandom_range(0, 3);
            serve(r, m < 2 ? GL : (m == 2 ? $urandom_range(0, 7) : 0), m == 3, $urandom_range(0, 2));
            if ($urandom_range(0, 3) == 0) begin
                bus.req = '0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end

        bus.req = '0;
        seq_to  = 1'b1;
        w       = pick(4'b0100);
        e0.g    = N'(1) << w;
        e0.ok   = 1'b0;
        e0.lat  = 0;
        sb.push_back(e0);
        bus.req = 4'b0100;
        repeat (4) @(posedge clk);
        @(negedge clk); #2;
        rst = 1'b0;
        #1;
        chk("reset_mid_run", {bus.grant, bus.done, bus.err, bus.busy, bus.seq_start, bus.seq_stop}, 0);
        sb.delete();
        last    = N - 1;
        bus.req = '0;
        repeat (2) @(posedge clk);
        @(negedge clk); #2;
        rst = 1'b1;
        serve(4'b1001, GL, 1'b0, 0);
        serve(4'b1001, GL, 1'b0, 0);
        bus.req = '0;
        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_empty", sb.size(), 0);
        finish_run();
    end

endmodule
